spi_camera_responder: RTL and testbench

SPI slave that emulates the camera at the far end of our SPI camera link: decodes register write/read commands and the 0x3C burst-read command, then streams pixel bytes taken from an AXI-Stream source out on MISO. It runs on the 100 MHz system clock, oversamples the SPI pins, and serves as the bench/loopback target for the SPI camera master and as a stand-in for a synthetic image source.

---
 rtl/camera_spi_pkg.sv | 18 +
 rtl/spi_pin_sync.sv | 48 ++++
 rtl/spi_camera_responder.sv | 170 +++++++++++++++++
 tb/tb_spi_camera_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_spi_pkg.sv
// Shared command/register codes and FSM state type for the SPI camera responder.
package camera_spi_pkg;

    localparam logic [7:0] CMD_BURST  = 8'h3C;
    localparam logic [7:0] REG_MODE   = 8'h21;
    localparam logic [7:0] REG_ID     = 8'h40;
    localparam logic [7:0] REG_STATUS = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_BURST,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the asynchronous SPI pins into clk and derives SCK fall / CS edges.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk_i,
    input  logic spi_cs_n_i,
    input  logic spi_mosi_i,
    output logic sck_fall_o,
    output logic cs_rise_o,
    output logic cs_fall_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q[0]  <= spi_clk_i;
            cs_sync_q[0]   <= spi_cs_n_i;
            mosi_sync_q[0] <= spi_mosi_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sck_sync_q[i]  <= sck_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_fall_o = sck_prev_q & ~sck_sync_q[SYNC_STAGES-1];
    assign cs_rise_o  = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
    assign cs_fall_o  = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
    assign mosi_o     = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_camera_responder.sv
// SPI slave emulating the camera: register read/write plus 0x3C pixel burst
// streamed from a one-deep AXI-Stream buffer.
module spi_camera_responder
    import camera_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'hA5,
    parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  mode_reg,
    output logic        burst_start,
    output logic        burst_active,
    output logic [15:0] pixel_count,
    output logic        underrun
);

    logic sck_fall, cs_rise, cs_fall, mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk        (clk),
        .rst        (rst),
        .spi_clk_i  (spi_clk),
        .spi_cs_n_i (spi_cs_n),
        .spi_mosi_i (spi_mosi),
        .sck_fall_o (sck_fall),
        .cs_rise_o  (cs_rise),
        .cs_fall_o  (cs_fall),
        .mosi_o     (mosi_s)
    );

    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_q;
    logic [7:0]  tx_q;
    logic        miso_q;
    logic [6:0]  addr_q;
    logic [7:0]  mode_q;
    logic [7:0]  buf_q;
    logic        buf_valid_q;
    logic        burst_start_q;
    logic        burst_active_q;
    logic [15:0] pixel_count_q;
    logic        underrun_q;

    logic [7:0]  rx_byte_d;
    logic [7:0]  rd_val_d;
    logic [7:0]  load_d;

    assign rx_byte_d = {rx_q[6:0], mosi_s};

    always_comb begin
        rd_val_d = FILL_BYTE;
        case ({1'b0, rx_byte_d[6:0]})
            REG_MODE:   rd_val_d = mode_q;
            REG_ID:     rd_val_d = ID_VALUE;
            REG_STATUS: rd_val_d = {7'b0, buf_valid_q};
            default:    rd_val_d = FILL_BYTE;
        endcase
    end

    // Byte placed into the TX path at a byte boundary, chosen by the current state.
    always_comb begin
        load_d = FILL_BYTE;
        case (state_q)
            ST_CMD:   if (rx_byte_d != CMD_BURST && rx_byte_d[7]) load_d = rd_val_d;
            ST_BURST: if (buf_valid_q) load_d = buf_q;
            default:  load_d = FILL_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            rx_q           <= '0;
            tx_q           <= '0;
            miso_q         <= 1'b0;
            addr_q         <= '0;
            mode_q         <= '0;
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
            burst_start_q  <= 1'b0;
            burst_active_q <= 1'b0;
            pixel_count_q  <= '0;
            underrun_q     <= 1'b0;
        end else begin
            burst_start_q <= 1'b0;
            underrun_q    <= 1'b0;

            if (s_axis_tvalid && !buf_valid_q) begin
                buf_q       <= s_axis_tdata;
                buf_valid_q <= 1'b1;
            end

            if (cs_rise) begin
                state_q        <= ST_IDLE;
                bit_cnt_q      <= '0;
                miso_q         <= 1'b0;
                burst_active_q <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (cs_fall) begin
                    state_q   <= ST_CMD;
                    bit_cnt_q <= '0;
                    miso_q    <= 1'b0;
                    tx_q      <= '0;
                end
            end else if (sck_fall) begin
                rx_q      <= rx_byte_d;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q != 3'd7) begin
                    miso_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end else begin
                    // Boundary: first bit of the new byte goes straight to MISO.
                    miso_q <= load_d[7];
                    tx_q   <= {load_d[6:0], 1'b0};
                    case (state_q)
                        ST_CMD: begin
                            if (rx_byte_d == CMD_BURST) begin
                                state_q        <= ST_BURST;
                                burst_start_q  <= 1'b1;
                                burst_active_q <= 1'b1;
                                pixel_count_q  <= '0;
                            end else if (rx_byte_d[7]) begin
                                state_q <= ST_RD_DATA;
                            end else begin
                                state_q <= ST_WR_DATA;
                                addr_q  <= rx_byte_d[6:0];
                            end
                        end
                        ST_WR_DATA: begin
                            if ({1'b0, addr_q} == REG_MODE) mode_q <= rx_byte_d;
                            state_q <= ST_DRAIN;
                        end
                        ST_RD_DATA: state_q <= ST_DRAIN;
                        ST_BURST: begin
                            if (buf_valid_q) begin
                                buf_valid_q <= 1'b0;
                                if (pixel_count_q != 16'hFFFF) pixel_count_q <= pixel_count_q + 16'd1;
                            end else begin
                                underrun_q <= 1'b1;
                            end
                        end
                        default: state_q <= state_q;
                    endcase
                end
            end
        end
    end

    assign spi_miso      = miso_q;
    assign s_axis_tready = !buf_valid_q;
    assign mode_reg      = mode_q;
    assign burst_start   = burst_start_q;
    assign burst_active  = burst_active_q;
    assign pixel_count   = pixel_count_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_spi_camera_responder.sv
// Self-checking bench: directed and randomized SPI transactions against a byte-level model.
module tb_spi_camera_responder;

    localparam logic [7:0] FILL = 8'h00;
    localparam logic [7:0] IDV  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  mode_reg;
    logic        burst_start;
    logic        burst_active;
    logic [15:0] pixel_count;
    logic        underrun;

    spi_camera_responder #(
        .SYNC_STAGES(2),
        .ID_VALUE   (8'hA5),
        .FILL_BYTE  (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_clk       (spi_clk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .mode_reg      (mode_reg),
        .burst_start   (burst_start),
        .burst_active  (burst_active),
        .pixel_count   (pixel_count),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;
    int n_under  = 0;

    // Pixel source: presents queued bytes, drops one on each accepted handshake.
    logic [7:0] src_q[$];
    always @(posedge clk) if (s_axis_tvalid && s_axis_tready) void'(src_q.pop_front());
    always @(negedge clk) begin
        s_axis_tvalid = (src_q.size() != 0);
        s_axis_tdata  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (burst_start) n_starts++;
            if (underrun)    n_under++;
        end
    end

    // Model state: mode register, pixels offered but not yet consumed, counters.
    logic [7:0]  m_mode = 8'h00;
    logic [7:0]  m_pix[$];
    logic [15:0] m_count = 16'h0;
    int          m_starts = 0;
    int          m_under  = 0;

    logic [7:0] txb[16];
    logic [7:0] rxb[16];
    logic [7:0] expb[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_reg(input logic [6:0] a);
        case ({1'b0, a})
            8'h21:   return m_mode;
            8'h40:   return IDV;
            8'h41:   return {7'b0, m_pix.size() != 0};
            default: return FILL;
        endcase
    endfunction

    // Expected MISO bytes for an n-byte transaction; updates the model state.
    task automatic model_txn(input int n);
        logic [7:0] cmd;
        logic [7:0] nxt;
        cmd = txb[0];
        for (int k = 0; k < 16; k++) expb[k] = FILL;
        expb[0] = 8'h00;
        if (cmd == 8'h3C) begin
            m_starts++;
            m_count = 16'h0;
            for (int k = 1; k < n; k++) begin
                if (m_pix.size() != 0) begin
                    nxt = m_pix.pop_front();
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                end else begin
                    nxt = FILL;
                    m_under++;
                end
                if (k + 1 < n) expb[k+1] = nxt;
            end
        end else if (cmd[7]) begin
            if (n > 1) expb[1] = m_reg(cmd[6:0]);
        end else begin
            if (n > 1 && cmd[6:0] == 7'h21) m_mode = txb[1];
        end
    endtask

    task automatic xfer(input logic [7:0] tb, input int nbits, output logic [7:0] rb);
        rb = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            rb[i]    = spi_miso;
            spi_mosi = tb[i];
            spi_clk  = 1'b1;
            #50;
            spi_clk  = 1'b0;
            #50;
        end
    endtask

    task automatic run_txn(input int n, input int partial);
        logic [7:0] junk;
        spi_cs_n = 1'b0;
        #100;
        for (int k = 0; k < n; k++) xfer(txb[k], 8, rxb[k]);
        if (partial > 0) xfer(txb[n], partial, junk);
        #100;
        spi_cs_n = 1'b1;
        #300;
    endtask

    task automatic feed(input int cnt, input logic [7:0] base, input bit rnd);
        logic [7:0] v;
        for (int i = 0; i < cnt; i++) begin
            v = rnd ? 8'($urandom) : base + 8'(i);
            src_q.push_back(v);
            m_pix.push_back(v);
        end
        #100;
    endtask

    task automatic check_txn(input string tag, input int n);
        for (int k = 0; k < n; k++) chk($sformatf("%s miso byte%0d", tag, k), 32'(rxb[k]), 32'(expb[k]));
        chk({tag, " mode_reg"},     32'(mode_reg),     32'(m_mode));
        chk({tag, " pixel_count"},  32'(pixel_count),  32'(m_count));
        chk({tag, " burst_active"}, 32'(burst_active), 32'h0);
        chk({tag, " burst_starts"}, 32'(n_starts),     32'(m_starts));
        chk({tag, " underruns"},    32'(n_under),      32'(m_under));
    endtask

    initial begin
        int n;
        int kind;
        logic [6:0] a;

        #3;
        #100;
        rst = 1'b0;
        #50;
        chk("reset miso",         32'(spi_miso),      32'h0);
        chk("reset tready",       32'(s_axis_tready), 32'h1);
        chk("reset mode_reg",     32'(mode_reg),      32'h0);
        chk("reset burst_start",  32'(burst_start),   32'h0);
        chk("reset burst_active", 32'(burst_active),  32'h0);
        chk("reset pixel_count",  32'(pixel_count),   32'h0);
        chk("reset underrun",     32'(underrun),      32'h0);

        txb[0] = 8'h21; txb[1] = 8'h0A; txb[2] = 8'hFF;
        model_txn(3); run_txn(3, 0); check_txn("write mode", 3);
        chk("write mode value", 32'(mode_reg), 32'h0A);

        txb[0] = 8'hC0; txb[1] = 8'h00;
        model_txn(2); run_txn(2, 0); check_txn("read id", 2);
        chk("read id value", 32'(rxb[1]), 32'hA5);

        txb[0] = 8'hA1; txb[1] = 8'h00;
        model_txn(2); run_txn(2, 0); check_txn("read mode", 2);

        feed(4, 8'h10, 1'b0);
        txb[0] = 8'h3C;
        for (int k = 1; k < 6; k++) txb[k] = 8'h00;
        model_txn(6); run_txn(6, 0); check_txn("burst4", 6);
        chk("burst4 pixel_count", 32'(pixel_count), 32'd4);

        feed(2, 8'h20, 1'b0);
        model_txn(5); run_txn(5, 0); check_txn("burst stall", 5);

        feed(3, 8'h30, 1'b0);
        txb[0] = 8'h3C; txb[1] = 8'h00; txb[2] = 8'h00;
        model_txn(2); run_txn(2, 3); check_txn("burst abort", 0);
        chk("abort burst_active", 32'(burst_active), 32'h0);
        model_txn(4); run_txn(4, 0); check_txn("burst after abort", 4);

        txb[0] = 8'hC1; txb[1] = 8'h00;
        model_txn(2); run_txn(2, 0); check_txn("read status", 2);

        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 2));
            for (int k = 0; k < 16; k++) txb[k] = 8'($urandom);
            if (kind == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 7'h21 : 7'($urandom);
                if (a == 7'h3C) a = 7'h21;
                txb[0] = {1'b0, a};
                n = 2 + int'($urandom_range(0, 1));
            end else if (kind == 1) begin
                case ($urandom_range(0, 3))
                    0: a = 7'h21;
                    1: a = 7'h40;
                    2: a = 7'h41;
                    default: a = 7'($urandom);
                endcase
                txb[0] = {1'b1, a};
                n = 2 + int'($urandom_range(0, 1));
            end else begin
                feed(int'($urandom_range(0, 4)), 8'h00, 1'b1);
                txb[0] = 8'h3C;
                n = int'($urandom_range(2, 6));
            end
            model_txn(n);
            run_txn(n, 0);
            check_txn($sformatf("rand%0d", it), n);
        end

        src_q.delete();
        m_pix.delete();
        #200;
        spi_cs_n = 1'b0;
        #100;
        xfer(8'h21, 8, rxb[0]);
        xfer(8'h55, 4, rxb[1]);
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #100;
        spi_cs_n = 1'b1;
        #300;
        m_mode = 8'h00;
        m_count = 16'h0;
        chk("rst mid-byte mode_reg",     32'(mode_reg),      32'h0);
        chk("rst mid-byte tready",       32'(s_axis_tready), 32'h1);
        chk("rst mid-byte burst_active", 32'(burst_active),  32'h0);
        chk("rst mid-byte pixel_count",  32'(pixel_count),   32'h0);
        chk("rst mid-byte miso",         32'(spi_miso),      32'h0);

        txb[0] = 8'hA1; txb[1] = 8'h00;
        model_txn(2); run_txn(2, 0);
        for (int k = 0; k < 2; k++) chk($sformatf("post-rst read byte%0d", k), 32'(rxb[k]), 32'(expb[k]));
        chk("post-rst mode_reg", 32'(mode_reg), 32'(m_mode));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
